// File: rtl/visor_sumador_if.sv
// Bus between the adder stage and the four-digit display scanner:
// result/load strobe towards the display, anode/segment drive out of it.
interface visor_sumador_if;
    logic [4:0] res_in;
    logic       cargar;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (output res_in, cargar, input  an, seg, dp);
    modport slave  (input  res_in, cargar, output an, seg, dp);
endinterface

// File: rtl/visor_sumador.sv
// Multiplexed 4-digit 7-segment driver for a signed 5-bit sum:
// sign on the leftmost digit, decimal magnitude on the two rightmost.
module visor_sumador #(
    parameter int DIV = 50000
) (
    input logic        clk,
    input logic        rst,
    visor_sumador_if.slave bus
);
    localparam int            CW      = $clog2(DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [6:0]    BLANK   = 7'h7F;
    localparam logic [6:0]    MINUS   = 7'h3F;

    logic [4:0]    valor;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [3:0]    mag;
    logic [3:0]    units;
    logic          tens;
    logic [6:0]    seg_d;

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    enc = 7'h40;
            4'd1:    enc = 7'h79;
            4'd2:    enc = 7'h24;
            4'd3:    enc = 7'h30;
            4'd4:    enc = 7'h19;
            4'd5:    enc = 7'h12;
            4'd6:    enc = 7'h02;
            4'd7:    enc = 7'h78;
            4'd8:    enc = 7'h00;
            4'd9:    enc = 7'h10;
            default: enc = BLANK;
        endcase
    endfunction

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        seg_d = BLANK;
        mag   = valor[3:0];
        tens  = (mag >= 4'd10);
        units = tens ? mag - 4'd10 : mag;
        case (idx)
            2'd0:    seg_d = enc(units);
            2'd1:    if (tens) seg_d = enc(4'd1);
            2'd3:    if (valor[4]) seg_d = MINUS;
            default: seg_d = BLANK;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values, matching real flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            valor   <= 5'd0;
            cnt     <= '0;
            idx     <= 2'd0;
            bus.an  <= 4'b1111;
            bus.seg <= BLANK;
            bus.dp  <= 1'b1;
        end else begin
            // A signed zero is stored as +0 so the minus sign never shows on "0".
            if (bus.cargar)
                valor <= (bus.res_in[3:0] == 4'd0) ? 5'd0 : bus.res_in;
            if (cnt == CNT_MAX) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            bus.an  <= ~(4'b0001 << idx);
            bus.seg <= seg_d;
            bus.dp  <= 1'b1;
        end
    end
endmodule

// File: tb/tb_visor_sumador.sv
// Directed bench for visor_sumador with DIV=4: scan order, digit content,
// negative-zero handling, mid-scan load and reset priority.
module tb_visor_sumador;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   k     = 0;   // edges since reset was released

    visor_sumador_if bus ();

    visor_sumador #(.DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    function automatic logic [3:0] exp_an(input int edge_no);
        int i;
        i = ((edge_no - 1) / 4) % 4;
        case (i)
            0:       exp_an = 4'b1110;
            1:       exp_an = 4'b1101;
            2:       exp_an = 4'b1011;
            default: exp_an = 4'b0111;
        endcase
    endfunction

    // Run one full 16-cycle scan; digs[i] is the segment code expected on digit i.
    task automatic scan(input string tag, input logic [6:0] digs [4]);
        for (int n = 0; n < 16; n++) begin
            tick();
            check({tag, "_an"},  bus.an,  exp_an(k));
            check({tag, "_seg"}, bus.seg, digs[((k - 1) / 4) % 4]);
            check({tag, "_dp"},  bus.dp,  1'b1);
        end
    endtask

    task automatic load(input logic [4:0] v);
        bus.res_in = v;
        bus.cargar = 1'b1;
        tick();
        bus.cargar = 1'b0;
    endtask

    logic [6:0] d_zero [4] = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
    logic [6:0] d_neg6 [4] = '{7'h02, 7'h7F, 7'h7F, 7'h3F};
    logic [6:0] d_p14  [4] = '{7'h19, 7'h79, 7'h7F, 7'h7F};

    initial begin
        rst        = 1'b1;
        bus.cargar = 1'b0;
        bus.res_in = 5'd0;
        tick();
        tick();
        check("rst_an",  bus.an,  4'b1111);
        check("rst_seg", bus.seg, 7'h7F);
        check("rst_dp",  bus.dp,  1'b1);

        rst = 1'b0;
        k   = 0;
        tick();
        check("first_an",  bus.an,  4'b1110);
        check("first_seg", bus.seg, 7'h40);
        for (int n = 1; n < 16; n++) begin
            tick();
            check("idle_an",  bus.an,  exp_an(k));
            check("idle_seg", bus.seg, d_zero[((k - 1) / 4) % 4]);
        end

        load(5'b10110);
        scan("neg6", d_neg6);
        load(5'b01110);
        scan("pos14", d_p14);
        load(5'b10000);
        scan("negzero", d_zero);

        // Mid-scan load: next edge sees idx=0, cnt=2.
        while ((k % 16) != 2) tick();
        bus.res_in = 5'b00011;
        bus.cargar = 1'b1;
        tick();
        check("midload_an",     bus.an,  exp_an(k));
        check("midload_oldseg", bus.seg, 7'h40);
        bus.cargar = 1'b0;
        tick();
        check("midload_seg", bus.seg, 7'h30);
        for (int n = 0; n < 6; n++) begin
            tick();
            check("midload_timing", bus.an, exp_an(k));
        end

        // Reset wins over a simultaneous load, mid-scan.
        rst        = 1'b1;
        bus.cargar = 1'b1;
        bus.res_in = 5'b01001;
        tick();
        check("rstld_an",  bus.an,  4'b1111);
        check("rstld_seg", bus.seg, 7'h7F);
        check("rstld_dp",  bus.dp,  1'b1);
        rst        = 1'b0;
        bus.cargar = 1'b0;
        k          = 0;
        tick();
        check("rstld_after_an",  bus.an,  4'b1110);
        check("rstld_after_seg", bus.seg, 7'h40);
        scan("post_rst", d_zero);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
